// File: rtl/pwm_ramp_controller_pkg.sv
// Shared types and constants for the PWM on-time ramp sequencer.
// Contents: ramp FSM state enum, ramp command bundle, interval floor.
package pwm_ramp_controller_pkg;

    localparam int RAMP_DW      = 32;
    localparam int RAMP_IW      = 16;
    localparam int INTERVAL_MIN = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_PERIOD,
        S_STEP,
        S_DONE
    } ramp_state_e;

    typedef struct packed {
        logic [RAMP_DW-1:0] period;
        logic [RAMP_DW-1:0] target_on;
        logic [RAMP_DW-1:0] step;
        logic [RAMP_IW-1:0] interval;
    } ramp_cmd_t;

endpackage

// File: rtl/pwm_ramp_controller_step_calc.sv
// Saturating next on-time toward a target, in either direction.
// Ports: cur_i/target_i/step_i in, next_o out (step 0 = jump to target).
module ramp_step_calc #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] cur_i,
    input  logic [DATA_WIDTH-1:0] target_i,
    input  logic [DATA_WIDTH-1:0] step_i,
    output logic [DATA_WIDTH-1:0] next_o
);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] gap;
    logic                  hold;
    logic                  up;
    logic                  dn;

    // One extra bit so cur + step can never wrap.
    assign sum  = {1'b0, cur_i} + {1'b0, step_i};
    assign gap  = cur_i - target_i;
    assign hold = (step_i == '0);
    assign up   = (cur_i < target_i);
    assign dn   = (cur_i > target_i);

    always_comb begin
        next_o = target_i;
        unique case (1'b1)
            (!hold && up): begin
                if (sum > {1'b0, target_i}) next_o = target_i;
                else                        next_o = sum[DATA_WIDTH-1:0];
            end
            (!hold && dn): begin
                // gap is only meaningful when cur > target.
                if (step_i >= gap) next_o = target_i;
                else               next_o = cur_i - step_i;
            end
            default: next_o = target_i;
        endcase
    end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Ramp sequencer feeding one PWM channel; timing changes only at period ends.
// Ports: cmd_* handshake in, abort/period_end in, t_period/t_on/update/status out.
module pwm_ramp_controller
    import pwm_ramp_controller_pkg::*;
#(
    parameter int DATA_WIDTH     = RAMP_DW,
    parameter int INTERVAL_WIDTH = RAMP_IW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [DATA_WIDTH-1:0]     cmd_period,
    input  logic [DATA_WIDTH-1:0]     cmd_target_on,
    input  logic [DATA_WIDTH-1:0]     cmd_step,
    input  logic [INTERVAL_WIDTH-1:0] cmd_interval,
    input  logic                      abort,
    input  logic                      period_end,
    output logic [DATA_WIDTH-1:0]     t_period,
    output logic [DATA_WIDTH-1:0]     t_on,
    output logic                      update,
    output logic                      pwm_enable,
    output logic                      ramp_busy,
    output logic                      ramp_done,
    output logic                      cmd_error
);

    ramp_state_e               state_q;
    ramp_cmd_t                 cmd_q;
    logic [INTERVAL_WIDTH-1:0] cnt_q;
    logic [INTERVAL_WIDTH-1:0] cnt_d;
    logic [INTERVAL_WIDTH-1:0] ivl_eff;
    logic [DATA_WIDTH-1:0]     t_period_q;
    logic [DATA_WIDTH-1:0]     t_on_q;
    logic [DATA_WIDTH-1:0]     t_on_d;
    logic                      update_q;
    logic                      pwm_enable_q;
    logic                      ramp_busy_q;
    logic                      ramp_done_q;
    logic                      cmd_error_q;
    logic                      cmd_bad;
    logic                      at_target;
    logic                      last_pe;

    assign cmd_ready = (state_q == S_IDLE) && !abort;
    assign cmd_bad   = (cmd_period == '0) ||
                       (cmd_target_on > cmd_period);

    // An interval of 0 behaves as 1 period.
    assign ivl_eff = (cmd_q.interval < INTERVAL_WIDTH'(INTERVAL_MIN))
                   ? INTERVAL_WIDTH'(INTERVAL_MIN) : cmd_q.interval;
    assign cnt_d     = cnt_q + INTERVAL_WIDTH'(1);
    assign at_target = (t_on_q == cmd_q.target_on);
    assign last_pe   = period_end && (cnt_d >= ivl_eff);

    ramp_step_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_calc (
        .cur_i    (t_on_q),
        .target_i (cmd_q.target_on),
        .step_i   (cmd_q.step),
        .next_o   (t_on_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            cnt_q        <= '0;
            t_period_q   <= '0;
            t_on_q       <= '0;
            update_q     <= 1'b0;
            pwm_enable_q <= 1'b0;
            ramp_busy_q  <= 1'b0;
            ramp_done_q  <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            update_q    <= 1'b0;
            ramp_done_q <= 1'b0;
            if (abort) begin
                state_q      <= S_IDLE;
                pwm_enable_q <= 1'b0;
                t_on_q       <= '0;
                update_q     <= 1'b1;
                ramp_busy_q  <= 1'b0;
                cnt_q        <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            if (cmd_bad) begin
                                cmd_error_q <= 1'b1;
                            end else begin
                                cmd_q <= '{period:    cmd_period,
                                           target_on: cmd_target_on,
                                           step:      cmd_step,
                                           interval:  cmd_interval};
                                cmd_error_q <= 1'b0;
                                ramp_busy_q <= 1'b1;
                                state_q     <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        // A running channel only reloads at a boundary.
                        if (!pwm_enable_q || period_end) begin
                            update_q     <= 1'b1;
                            t_period_q   <= cmd_q.period;
                            pwm_enable_q <= 1'b1;
                            cnt_q        <= '0;
                            state_q      <= S_WAIT_PERIOD;
                        end
                    end
                    S_WAIT_PERIOD: begin
                        if (at_target) begin
                            ramp_done_q <= 1'b1;
                            ramp_busy_q <= 1'b0;
                            state_q     <= S_DONE;
                        end else if (last_pe) begin
                            // New on-time is presented in the STEP cycle.
                            t_on_q   <= t_on_d;
                            update_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= S_STEP;
                        end else if (period_end) begin
                            cnt_q <= cnt_d;
                        end
                    end
                    S_STEP: begin
                        if (at_target) begin
                            ramp_done_q <= 1'b1;
                            ramp_busy_q <= 1'b0;
                            state_q     <= S_DONE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_WAIT_PERIOD;
                        end
                    end
                    S_DONE: state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign t_period   = t_period_q;
    assign t_on       = t_on_q;
    assign update     = update_q;
    assign pwm_enable = pwm_enable_q;
    assign ramp_busy  = ramp_busy_q;
    assign ramp_done  = ramp_done_q;
    assign cmd_error  = cmd_error_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller.
// Drives commands and period_end pulses, checks strobes and on-time values.
module tb_pwm_ramp_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_period = '0;
    logic [31:0] cmd_target_on = '0;
    logic [31:0] cmd_step = '0;
    logic [15:0] cmd_interval = '0;
    logic        abort = 1'b0;
    logic        period_end = 1'b0;
    logic [31:0] t_period;
    logic [31:0] t_on;
    logic        update;
    logic        pwm_enable;
    logic        ramp_busy;
    logic        ramp_done;
    logic        cmd_error;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    pwm_ramp_controller dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_period    (cmd_period),
        .cmd_target_on (cmd_target_on),
        .cmd_step      (cmd_step),
        .cmd_interval  (cmd_interval),
        .abort         (abort),
        .period_end    (period_end),
        .t_period      (t_period),
        .t_on          (t_on),
        .update        (update),
        .pwm_enable    (pwm_enable),
        .ramp_busy     (ramp_busy),
        .ramp_done     (ramp_done),
        .cmd_error     (cmd_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pe_pulse(input int idle);
        repeat (idle) tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic send(input logic [31:0] p, input logic [31:0] t,
                        input logic [31:0] s, input logic [15:0] i);
        cmd_period    = p;
        cmd_target_on = t;
        cmd_step      = s;
        cmd_interval  = i;
        cmd_valid     = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int unsigned dn[4];
        dn = '{300, 200, 100, 50};

        // reset state
        repeat (2) tick();
        chk("rst_tper", t_period, 0);
        chk("rst_ton", t_on, 0);
        chk("rst_upd", update, 0);
        chk("rst_en", pwm_enable, 0);
        chk("rst_busy", ramp_busy, 0);
        chk("rst_done", ramp_done, 0);
        chk("rst_err", cmd_error, 0);
        chk("rst_rdy", cmd_ready, 1);
        reset = 1'b1;
        tick();

        // cold start ramp up, interval 2
        send(1000, 400, 100, 2);
        chk("c_busy", ramp_busy, 1);
        chk("c_rdy", cmd_ready, 0);
        tick();
        chk("c_ld_upd", update, 1);
        chk("c_ld_en", pwm_enable, 1);
        chk("c_ld_tper", t_period, 1000);
        chk("c_ld_ton", t_on, 0);
        for (int k = 1; k <= 4; k++) begin
            pe_pulse(999);
            chk("c_pe1_upd", update, 0);
            chk("c_pe1_ton", t_on, 64'(100 * (k - 1)));
            pe_pulse(999);
            chk("c_pe2_upd", update, 1);
            chk("c_pe2_ton", t_on, 64'(100 * k));
        end
        tick();
        chk("c_done", ramp_done, 1);
        chk("c_busy_lo", ramp_busy, 0);
        tick();
        chk("c_done_lo", ramp_done, 0);
        chk("c_en_kept", pwm_enable, 1);
        chk("c_rdy_hi", cmd_ready, 1);

        // ramp down with clamp at target
        send(1000, 50, 100, 1);
        tick();
        chk("d_ld_wait", update, 0);
        pe_pulse(5);
        chk("d_ld_upd", update, 1);
        chk("d_ld_ton", t_on, 400);
        for (int k = 0; k < 4; k++) begin
            pe_pulse(20);
            chk("d_upd", update, 1);
            chk("d_ton", t_on, 64'(dn[k]));
        end
        tick();
        chk("d_done", ramp_done, 1);
        tick();

        // rejected commands
        send(1000, 1200, 100, 1);
        chk("e1_err", cmd_error, 1);
        chk("e1_upd", update, 0);
        chk("e1_busy", ramp_busy, 0);
        tick();
        chk("e1_rdy", cmd_ready, 1);
        send(0, 0, 100, 1);
        chk("e2_err", cmd_error, 1);
        chk("e2_upd", update, 0);
        send(1000, 400, 100, 1);
        chk("e3_err_clr", cmd_error, 0);
        chk("e3_busy", ramp_busy, 1);

        // abort in WAIT_PERIOD with a competing command
        pe_pulse(3);
        chk("a_ld_upd", update, 1);
        repeat (3) tick();
        abort         = 1'b1;
        cmd_valid     = 1'b1;
        cmd_period    = 500;
        cmd_target_on = 100;
        #1;
        chk("a_rdy_lo", cmd_ready, 0);
        tick();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        chk("a_en", pwm_enable, 0);
        chk("a_ton", t_on, 0);
        chk("a_upd", update, 1);
        chk("a_busy", ramp_busy, 0);
        chk("a_done", ramp_done, 0);
        chk("a_tper", t_period, 1000);
        tick();
        chk("a_busy2", ramp_busy, 0);
        chk("a_upd2", update, 0);
        chk("a_rdy", cmd_ready, 1);

        // step 0 / interval 0: single jump
        send(1000, 700, 0, 0);
        tick();
        chk("j_ld_upd", update, 1);
        chk("j_ld_ton", t_on, 0);
        pe_pulse(10);
        chk("j_upd", update, 1);
        chk("j_ton", t_on, 700);
        tick();
        chk("j_done", ramp_done, 1);
        tick();

        // overflow saturation
        send(32'hFFFF_FFFF, 32'h20, 0, 1);
        pe_pulse(3);
        pe_pulse(3);
        chk("o_pre_ton", t_on, 32'h20);
        tick();
        tick();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1);
        pe_pulse(3);
        chk("o_tper", t_period, 32'hFFFF_FFFF);
        pe_pulse(3);
        chk("o_ton_sat", t_on, 32'hFFFF_FFFF);
        tick();
        chk("o_done", ramp_done, 1);
        tick();

        // async reset mid-ramp
        send(1000, 0, 1, 5);
        pe_pulse(3);
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("r_tper", t_period, 0);
        chk("r_ton", t_on, 0);
        chk("r_en", pwm_enable, 0);
        chk("r_busy", ramp_busy, 0);
        chk("r_upd", update, 0);
        chk("r_rdy", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_controller.md
Name: pwm_ramp_controller

Overview:
Sequencer that drives one PWM channel datapath with a controlled on-time ramp (soft start/stop for motor drives).
Accepts a ramp command (period, target on-time, step, interval) over a valid/ready handshake. Steps the channel on-time toward the target by a fixed increment every N PWM periods. Presents new timing values only at PWM period boundaries, so no pulse is ever truncated or glitched.
Sits between the register/bus layer and the PWM channel datapath.

Parameters:
DATA_WIDTH, 32, width of period/on-time/step values (units of 20 ns)
INTERVAL_WIDTH, 16, width of the step-interval count (units of PWM periods)

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  ramp command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_period  input  DATA_WIDTH  requested PWM period
cmd_target_on  input  DATA_WIDTH  requested final on-time
cmd_step  input  DATA_WIDTH  on-time increment per step; 0 = jump to target
cmd_interval  input  INTERVAL_WIDTH  PWM periods between steps; 0 treated as 1
abort  input  1  emergency stop, level-sampled each cycle
period_end  input  1  one-cycle pulse from the PWM datapath at each period boundary
t_period  output  DATA_WIDTH  period value to the datapath
t_on  output  DATA_WIDTH  on-time value to the datapath
update  output  1  one-cycle strobe: datapath loads t_period/t_on
pwm_enable  output  1  channel enable
ramp_busy  output  1  ramp in progress
ramp_done  output  1  one-cycle pulse when target reached
cmd_error  output  1  sticky; last command rejected

Behaviour:
- Reset values:
  - t_period = 0, t_on = 0, update = 0, pwm_enable = 0, ramp_busy = 0, ramp_done = 0, cmd_error = 0.
  - cmd_ready = 1. State = IDLE, interval counter = 0.
- States: IDLE, LOAD, WAIT_PERIOD, STEP, DONE.
- IDLE:
  - A handshake occurs when cmd_valid && cmd_ready.
  - The command is rejected when cmd_period == 0 or cmd_target_on > cmd_period. On rejection: cmd_error = 1, stay in IDLE, no outputs change.
  - Otherwise: latch all command fields, clear cmd_error, go to LOAD, ramp_busy = 1.
- LOAD:
  - If pwm_enable == 0: next cycle update = 1, t_period = latched period, t_on unchanged, pwm_enable = 1.
  - If pwm_enable == 1: wait for period_end; the update strobe with the new t_period is asserted in the cycle after period_end is sampled high.
  - Then go to WAIT_PERIOD with the interval counter cleared.
- WAIT_PERIOD:
  - Count period_end pulses.
  - When count == max(cmd_interval, 1), go to STEP in the same cycle as the final period_end.
- STEP (one cycle):
  - If t_on < target: t_on = min(t_on + step, target), computed DATA_WIDTH+1 wide, so there is no wrap-around.
  - If t_on > target: t_on = max(t_on − step, target), with no underflow.
  - If step == 0: t_on = target.
  - update = 1 in this cycle, so update lands exactly one cycle after the qualifying period_end.
  - If new t_on == target, go to DONE; else go to WAIT_PERIOD with the counter cleared.
  - If t_on == target on entry to WAIT_PERIOD (no-op ramp), go directly to DONE without an update.
- DONE (one cycle):
  - ramp_done = 1, ramp_busy = 0, then go to IDLE.
  - pwm_enable stays 1.
  - A target of 0 leaves the channel enabled with zero on-time.
- abort (highest priority, any state including IDLE):
  - Next cycle: pwm_enable = 0, t_on = 0, update = 1, ramp_busy = 0, state = IDLE.
  - No ramp_done pulse. t_period is retained.
  - A cmd_valid in the abort cycle is not accepted, because cmd_ready is forced low while abort = 1.
- period_end arriving in IDLE or DONE is ignored.
- Simultaneous period_end and STEP completion cannot occur, because STEP lasts one cycle and period_end is at most one pulse per period (period ≥ 2 cycles is required of the datapath).
- Reset asserted mid-ramp: all outputs go immediately to their reset values. The datapath sees pwm_enable = 0.

Decomposition:
- Shared package (global constants): RAMP state enum typedef; INTERVAL_MIN = 1; ramp command struct (period, target_on, step, interval).
- One natural sub-module: ramp_step_calc. It is combinational and computes saturating next t_on from (t_on, target, step) with direction detection, so it can be unit-tested alone.

Test Plan:
1. Cold start:
   - Stimulus: period=1000, target=400, step=100, interval=2, period_end every 1000 cycles.
   - Response: immediate update with t_on=0, pwm_enable=1. Then t_on updates 100, 200, 300, 400, each one cycle after every 2nd period_end. ramp_done pulses once after 400; ramp_busy is low afterwards.
2. Ramp down with saturation:
   - Stimulus: from t_on=400, send target=50, step=100, interval=1.
   - Response: t_on = 300, 200, 100, 50 (clamped, no underflow). LOAD waits for period_end before the first update.
3. Invalid commands:
   - Stimulus: target=1200 with period=1000, then period=0.
   - Response: cmd_error=1 both times; state stays IDLE; no update. A following valid command clears cmd_error.
4. Abort mid-ramp:
   - Stimulus: abort asserted during WAIT_PERIOD, with cmd_valid high in the same cycle.
   - Response: next cycle pwm_enable=0, t_on=0, update=1, ramp_busy=0, no ramp_done. The command is not accepted.
5. Edge parameters:
   - Stimulus: step=0, interval=0, target=700.
   - Response: a single update to t_on=700 after the first period_end following LOAD; ramp_done pulses.
6. Overflow and reset:
   - Overflow stimulus: period=target=0xFFFF_FFFF, step=0xFFFF_FFF0 from t_on=0x20. Required response: t_on saturates at 0xFFFF_FFFF.
   - Reset stimulus: reset pulled low mid-ramp. Required response: all outputs at reset values asynchronously.
